// File: rtl/avalon_pio_led_pwm.sv
// Avalon-MM LED output port: DATA register with atomic set/clear, per-line
// blink gating from a shared prescaler, and global PWM brightness.

// One output line: registered gate of data bit by blink phase and PWM.
module avalon_pio_led_pwm_lane (
  input  logic clk,
  input  logic reset,
  input  logic rst_val,
  input  logic data,
  input  logic blink_en,
  input  logic phase,
  input  logic pwm_on,
  output logic q
);

  // Output flop; a line with blink disabled ignores the phase.
  always_ff @(posedge clk) begin
    if (reset) q <= rst_val;
    else       q <= data & (~blink_en | phase) & pwm_on;
  end

endmodule

module avalon_pio_led_pwm #(
  parameter int unsigned WIDTH       = 4,
  parameter logic [31:0] RESET_VALUE = 32'hF,
  parameter int unsigned PWM_BITS    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_SET    = 3'd1;
  localparam logic [2:0] A_CLR    = 3'd2;
  localparam logic [2:0] A_BLEN   = 3'd3;
  localparam logic [2:0] A_PERIOD = 3'd4;
  localparam logic [2:0] A_DUTY   = 3'd5;
  localparam logic [2:0] A_STATUS = 3'd6;

  logic [WIDTH-1:0]    data_q;
  logic [WIDTH-1:0]    blink_en_q;
  logic [31:0]         period_q;
  logic [PWM_BITS-1:0] duty_q;
  logic [31:0]         presc_q;
  logic                phase_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                pwm_on;
  logic                wr_en;
  logic                period_wr;
  logic                unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign period_wr = wr_en && (address == A_PERIOD);
  assign pwm_on    = (pwm_cnt_q < duty_q) || (duty_q == '1);
  // Bits above the register widths are deliberately dropped.
  assign unused_wd = ^writedata;

  // Register file writes; reset overrides any concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= RESET_VALUE[WIDTH-1:0];
      blink_en_q <= '0;
      period_q   <= '0;
      duty_q     <= '1;
    end else if (wr_en) begin
      case (address)
        A_DATA:   data_q     <= writedata[WIDTH-1:0];
        A_SET:    data_q     <= data_q | writedata[WIDTH-1:0];
        A_CLR:    data_q     <= data_q & ~writedata[WIDTH-1:0];
        A_BLEN:   blink_en_q <= writedata[WIDTH-1:0];
        A_PERIOD: period_q   <= writedata;
        A_DUTY:   duty_q     <= writedata[PWM_BITS-1:0];
        default:  ;
      endcase
    end
  end

  // Blink prescaler: phase toggles every period+1 clocks; a period write
  // restarts the sequence from phase high so the new rate starts cleanly.
  always_ff @(posedge clk) begin
    if (reset || period_wr || period_q == '0) begin
      presc_q <= '0;
      phase_q <= 1'b1;
    end else if (presc_q == period_q) begin
      presc_q <= '0;
      phase_q <= ~phase_q;
    end else begin
      presc_q <= presc_q + 32'd1;
    end
  end

  // Free-running PWM counter, wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (reset) pwm_cnt_q <= '0;
    else       pwm_cnt_q <= pwm_cnt_q + 1'b1;
  end

  // Zero-latency read mux; reflects state before any same-cycle write.
  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:   readdata[WIDTH-1:0]    = data_q;
      A_BLEN:   readdata[WIDTH-1:0]    = blink_en_q;
      A_PERIOD: readdata               = period_q;
      A_DUTY:   readdata[PWM_BITS-1:0] = duty_q;
      A_STATUS: begin
        readdata[0]             = phase_q;
        readdata[16 +: PWM_BITS] = pwm_cnt_q;
      end
      default:  readdata = '0;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    avalon_pio_led_pwm_lane u_lane (
      .clk      (clk),
      .reset    (reset),
      .rst_val  (RESET_VALUE[i]),
      .data     (data_q[i]),
      .blink_en (blink_en_q[i]),
      .phase    (phase_q),
      .pwm_on   (pwm_on),
      .q        (out_port[i])
    );
  end

endmodule

// File: tb/tb_avalon_pio_led_pwm.sv
// Bench for avalon_pio_led_pwm: constant vector table, directed blink/PWM/
// reset sequences, then random traffic against a time-based reference model.
module tb_avalon_pio_led_pwm;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  out_port;

  avalon_pio_led_pwm #(.WIDTH(4), .RESET_VALUE(32'hF), .PWM_BITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  // Reference model: register contents plus elapsed-edge counters; blink
  // phase and PWM count are derived arithmetically from elapsed time.
  logic [3:0]  m_data, m_ben, m_out;
  logic [31:0] m_per;
  logic [7:0]  m_duty;
  longint      m_n;     // edges since last period write / reset
  int          m_t;     // edges since reset
  bit          model_valid = 0;

  logic [31:0] last_rd;
  logic [3:0]  last_out;

  function automatic bit m_phase();
    if (m_per == 0) return 1'b1;
    return ((m_n / (longint'(m_per) + 1)) % 2) == 0;
  endfunction

  function automatic logic [7:0] m_cnt();
    return m_t[7:0];
  endfunction

  function automatic bit m_pwm();
    return (m_duty == 8'hFF) || (m_cnt() < m_duty);
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] a);
    case (a)
      3'd0:    return {28'd0, m_data};
      3'd3:    return {28'd0, m_ben};
      3'd4:    return m_per;
      3'd5:    return {24'd0, m_duty};
      3'd6:    return {8'd0, m_cnt(), 15'd0, m_phase()};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
  endtask

  task automatic model_edge(input bit rst, input bit cs, input bit wn,
                            input logic [2:0] a, input logic [31:0] wd);
    logic [3:0] nout;
    if (rst) begin
      m_data = 4'hF; m_ben = 4'h0; m_per = 0; m_duty = 8'hFF;
      m_n = 0; m_t = 0; m_out = 4'hF; model_valid = 1;
    end else begin
      nout = m_data & (~m_ben | {4{m_phase()}}) & {4{m_pwm()}};
      m_n++;
      m_t++;
      if (cs && !wn) begin
        case (a)
          3'd0: m_data = wd[3:0];
          3'd1: m_data = m_data | wd[3:0];
          3'd2: m_data = m_data & ~wd[3:0];
          3'd3: m_ben  = wd[3:0];
          3'd4: begin m_per = wd; m_n = 0; end
          3'd5: m_duty = wd[7:0];
          default: ;
        endcase
      end
      m_out = nout;
    end
  endtask

  // One bus cycle: drive, check read mux before the edge, check output after.
  task automatic cyc(input bit rst, input bit cs, input bit wn,
                     input logic [2:0] a, input logic [31:0] wd);
    reset = rst; chipselect = cs; write_n = wn; address = a; writedata = wd;
    #3;
    last_rd = readdata;
    if (model_valid) check("rd_model", readdata, m_rd(a));
    @(posedge clk);
    model_edge(rst, cs, wn, a, wd);
    #1;
    last_out = out_port;
    if (model_valid) check("out_model", out_port, {28'd0, m_out});
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    cyc(0, 1, 0, a, wd);
  endtask

  task automatic idle(input logic [2:0] a);
    cyc(0, 1, 1, a, 32'd0);
  endtask

  typedef struct {
    bit          rst, cs, wn;
    logic [2:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [3:0]  exp_out;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int on_cnt, off_cnt, other;
    vecs[0]  = '{0,1,1,3'd0,32'h0,        32'hF,  4'hF};
    vecs[1]  = '{0,1,1,3'd5,32'h0,        32'hFF, 4'hF};
    vecs[2]  = '{0,1,0,3'd0,32'h5,        32'hF,  4'hF};
    vecs[3]  = '{0,1,1,3'd0,32'h0,        32'h5,  4'h5};
    vecs[4]  = '{0,1,0,3'd1,32'h2,        32'h0,  4'h5};
    vecs[5]  = '{0,1,1,3'd0,32'h0,        32'h7,  4'h7};
    vecs[6]  = '{0,1,0,3'd2,32'h4,        32'h0,  4'h7};
    vecs[7]  = '{0,1,1,3'd0,32'h0,        32'h3,  4'h3};
    vecs[8]  = '{0,0,0,3'd0,32'h0,        32'h3,  4'h3};
    vecs[9]  = '{0,1,1,3'd0,32'h0,        32'h3,  4'h3};
    vecs[10] = '{0,1,1,3'd7,32'h0,        32'h0,  4'h3};
    vecs[11] = '{0,1,0,3'd7,32'hFFFFFFFF, 32'h0,  4'h3};
    vecs[12] = '{0,1,1,3'd0,32'h0,        32'h3,  4'h3};
    vecs[13] = '{0,1,0,3'd0,32'hFFFFFFF0, 32'h3,  4'h3};
    vecs[14] = '{0,1,1,3'd0,32'h0,        32'h0,  4'h0};

    reset = 1; chipselect = 0; write_n = 1; address = 0; writedata = 0;
    #1;
    cyc(1, 0, 1, 3'd0, 32'd0);
    cyc(1, 0, 1, 3'd0, 32'd0);
    check("reset_out", {28'd0, last_out}, 32'hF);

    // Table: reset reads, DATA/OUTSET/OUTCLEAR, chipselect gating, reserved.
    for (int i = 0; i < 15; i++) begin
      cyc(vecs[i].rst, vecs[i].cs, vecs[i].wn, vecs[i].a, vecs[i].wd);
      check($sformatf("vec%0d_rd", i), last_rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_out", i), {28'd0, last_out}, {28'd0, vecs[i].exp_out});
    end

    // Blink: bit0 toggles every 4 clocks starting high, others steady.
    wr(3'd0, 32'hF);
    wr(3'd3, 32'h1);
    wr(3'd4, 32'd3);
    for (int k = 1; k <= 12; k++) begin
      idle(3'd0);
      check($sformatf("blink_b0_%0d", k), {31'd0, last_out[0]},
            {31'd0, ((k - 1) / 4) % 2 == 0});
      check($sformatf("blink_hi_%0d", k), {29'd0, last_out[3:1]}, 32'h7);
    end
    wr(3'd4, 32'd0);
    for (int k = 0; k < 8; k++) begin
      idle(3'd6);
      check("blink_stalled", {31'd0, last_out[0]}, 32'h1);
    end

    // PWM: duty 64 gives 64 on / 192 off per period; 0 and 255 are solid.
    wr(3'd3, 32'h0);
    wr(3'd0, 32'hF);
    wr(3'd5, 32'd64);
    on_cnt = 0; off_cnt = 0; other = 0;
    for (int k = 0; k < 256; k++) begin
      idle(3'd6);
      if (last_out == 4'hF) on_cnt++;
      else if (last_out == 4'h0) off_cnt++;
      else other++;
    end
    check("pwm64_on", on_cnt, 64);
    check("pwm64_off", off_cnt, 192);
    check("pwm64_other", other, 0);
    wr(3'd5, 32'd0);
    on_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      idle(3'd0);
      if (last_out != 4'h0) on_cnt++;
    end
    check("pwm0_nonzero", on_cnt, 0);
    wr(3'd5, 32'd255);
    off_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      idle(3'd0);
      if (last_out != 4'hF) off_cnt++;
    end
    check("pwm255_notfull", off_cnt, 0);

    // Reset concurrent with a DATA write while the blink phase is low.
    wr(3'd3, 32'hF);
    wr(3'd4, 32'd2);
    idle(3'd0);
    idle(3'd0);
    idle(3'd0);
    idle(3'd6);
    check("pre_rst_phase", {31'd0, last_rd[0]}, 32'h0);
    cyc(1, 1, 0, 3'd0, 32'h0);
    check("rst_win_out", {28'd0, last_out}, 32'hF);
    idle(3'd6);
    check("rst_status", last_rd, 32'h1);
    check("rst_out_next", {28'd0, last_out}, 32'hF);
    idle(3'd0);
    check("rst_data", last_rd, 32'hF);
    idle(3'd3);
    check("rst_blink_en", last_rd, 32'h0);
    idle(3'd4);
    check("rst_period", last_rd, 32'h0);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      bit rst, cs, wn;
      logic [2:0] a;
      logic [31:0] wd;
      rst = ($urandom_range(0, 299) == 0);
      cs  = ($urandom_range(0, 3) != 0);
      wn  = ($urandom_range(0, 2) != 0);
      a   = 3'($urandom_range(0, 7));
      if (a == 3'd4)      wd = $urandom_range(0, 6);
      else if (a == 3'd5) wd = ($urandom_range(0, 3) == 0) ? 32'hFF : $urandom;
      else                wd = $urandom;
      cyc(rst, cs, wn, a, wd);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
